// File: rtl/rom_upload_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// rom_upload_ctrl_pkg : state enum, size defaults and byte order for the ROM upload sequencer. Rev 1.0
// ============================================================================
package rom_upload_ctrl_pkg;

  localparam int ADDR_W_DEF    = 14;
  localparam int LEN_W_DEF     = 16;
  localparam bit BYTE_ORDER_LE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rom_upload_ctrl_if.sv
`default_nettype none
// ============================================================================
// rom_upload_ctrl_if : UART byte stream, ROM upload port and CPU status bundle. Rev 1.0
// ============================================================================
interface rom_upload_ctrl_if
  import rom_upload_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);

  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              upg_wen;
  logic [ADDR_W-1:0] upg_adr;
  logic [31:0]       upg_dat;
  logic              upg_done;
  logic              cpu_hold;
  logic              err;
  logic [LEN_W-1:0]  words_loaded;

  modport master (
    input  start, rx_data, rx_valid,
    output rx_ready, upg_wen, upg_adr, upg_dat, upg_done, cpu_hold, err, words_loaded
  );

  modport slave (
    output start, rx_data, rx_valid,
    input  rx_ready, upg_wen, upg_adr, upg_dat, upg_done, cpu_hold, err, words_loaded
  );

endinterface
`default_nettype wire

// File: rtl/rom_upload_ctrl_assembler.sv
`default_nettype none
// ============================================================================
// upload_word_assembler : packs accepted bytes into a 32-bit word, 2-bit lane index. Rev 1.0
// ============================================================================
module upload_word_assembler
  import rom_upload_ctrl_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [7:0]  i_byte,
  input  wire logic        i_accept,
  input  wire logic        i_clear,
  output logic      [31:0] o_word,
  output logic             o_word_full
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic [1:0]  w_lane;

  assign w_lane = BYTE_ORDER_LE ? r_idx : ~r_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_clear) begin
      r_idx <= 2'd0;
    end else if (i_accept) begin
      r_word[{w_lane, 3'b000} +: 8] <= i_byte;
      r_idx                         <= r_idx + 2'd1;
    end
  end

  assign o_word      = r_word;
  // Full is flagged with the 4th byte so the write cycle follows immediately.
  assign o_word_full = i_accept && (r_idx == 2'd3);

endmodule
`default_nettype wire

// File: rtl/rom_upload_ctrl.sv
`default_nettype none
// ============================================================================
// rom_upload_ctrl : loads UART bytes into program ROM while holding the CPU; UPLOAD_TIMEOUT_EN adds idle timeout. Rev 1.0
// ============================================================================
module rom_upload_ctrl
  import rom_upload_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
`ifdef UPLOAD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input wire logic          clk,
  input wire logic          rst,
  rom_upload_ctrl_if.master bus
);

  localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

  state_t            r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_len, w_len_nxt;
  logic [ADDR_W-1:0] r_adr, w_adr_nxt;
  logic [LEN_W-1:0]  r_words, w_words_nxt;
  logic              r_err, w_err_nxt;
  logic              w_clear;
  logic              w_rx_ready;
  logic              w_accept;
  logic              w_tmo_hit;
  logic [LEN_W-1:0]  w_len_full;
  logic [LEN_W-1:0]  w_words_inc;
  logic [31:0]       w_word;
  logic              w_word_full;

  assign w_rx_ready  = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) || (r_state == ST_DATA);
  assign w_accept    = bus.rx_valid && w_rx_ready;
  assign w_len_full  = LEN_W'({bus.rx_data, r_len[7:0]});
  assign w_words_inc = r_words + LEN_W'(1);

  upload_word_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .i_byte      (bus.rx_data),
    .i_accept    (w_accept && (r_state == ST_DATA)),
    .i_clear     (w_clear),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

`ifdef UPLOAD_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo;

  // Held at zero in IDLE so the count starts fresh on entry to LEN_LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo <= '0;
    end else if (w_accept || (r_state == ST_IDLE)) begin
      r_tmo <= '0;
    end else if (w_rx_ready) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  assign w_tmo_hit = w_rx_ready && !w_accept && (r_tmo == TMO_LAST);
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_adr   <= '0;
      r_words <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_adr   <= w_adr_nxt;
      r_words <= w_words_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_adr_nxt   = r_adr;
    w_words_nxt = r_words;
    w_err_nxt   = r_err;
    w_clear     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_LEN_LO;
          w_adr_nxt   = '0;
          w_words_nxt = '0;
          w_err_nxt   = 1'b0;
          w_clear     = 1'b1;
        end
      end
      ST_LEN_LO: begin
        if (w_accept) begin
          w_len_nxt   = LEN_W'(bus.rx_data);
          w_state_nxt = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (w_accept) begin
          w_len_nxt = w_len_full;
          if (w_len_full == '0) begin
            w_state_nxt = ST_DONE;
          end else if (33'(w_len_full) > DEPTH) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_word_full) begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_adr_nxt   = r_adr + ADDR_W'(1);
        w_words_nxt = w_words_inc;
        w_state_nxt = (w_words_inc == r_len) ? ST_DONE : ST_DATA;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_tmo_hit) begin
      w_err_nxt   = 1'b1;
      w_state_nxt = ST_DONE;
    end
  end

  // ROM ownership returns in DONE; the CPU leaves reset only once back in IDLE.
  assign bus.rx_ready     = w_rx_ready;
  assign bus.upg_wen      = (r_state == ST_WRITE);
  assign bus.upg_adr      = r_adr;
  assign bus.upg_dat      = w_word;
  assign bus.upg_done     = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign bus.cpu_hold     = (r_state != ST_IDLE);
  assign bus.err          = r_err;
  assign bus.words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_rom_upload_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rom_upload_ctrl : randomized bench for rom_upload_ctrl with a byte-stream reference model. Rev 1.0
// ============================================================================
module tb_rom_upload_ctrl;

  localparam int ADDR_W = 14;
  localparam int LEN_W  = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [7:0]        bq_t[$];
  typedef logic [ADDR_W+31:0] wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rom_upload_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  rom_upload_ctrl #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
`ifdef UPLOAD_TIMEOUT_EN
    , .TIMEOUT_CYCLES (100)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t  got_q[$];
  wr_t  exp_q[$];
  logic exp_err;
  int   exp_words;
  int   ncyc = 0;
  int   done_rise = -1;
  int   hold_fall = -1;
  logic prev_done = 1'b1;
  logic prev_hold = 1'b0;

  // Observe DUT on the falling edge, away from the active edge.
  always @(negedge clk) begin
    ncyc++;
    if (bus.upg_wen) got_q.push_back({bus.upg_adr, bus.upg_dat});
    if (bus.upg_done && !prev_done) done_rise = ncyc;
    if (!bus.cpu_hold && prev_hold) hold_fall = ncyc;
    prev_done = bus.upg_done;
    prev_hold = bus.cpu_hold;
  end

  // Reference: header is a little-endian word count, payload is little-endian words.
  function automatic void model(input bq_t s);
    int len;
    exp_q.delete();
    len     = int'({s[1], s[0]});
    exp_err = (len > DEPTH);
    if (!exp_err) begin
      for (int w = 0; w < len; w++) begin
        exp_q.push_back({ADDR_W'(w), s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]});
      end
    end
    exp_words = exp_q.size();
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n;
    n = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (n) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int t = 0; t < 100 && !bus.rx_ready; t++) @(negedge clk);
    if (!bus.rx_ready) begin
      checks++; errors++;
      $display("FAIL rx_ready_wait rx_ready=0 required 1 within 100 cycles");
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_upload(input bq_t s, input int gap_max, input int mid_start);
    got_q.delete();
    done_rise = -1;
    hold_fall = -1;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int i = 0; i < s.size(); i++) begin
      if (i == mid_start) begin
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
      send_byte(s[i], gap_max);
    end
    for (int t = 0; t < 50 && bus.cpu_hold; t++) @(negedge clk);
    if (bus.cpu_hold) begin
      checks++; errors++;
      $display("FAIL release_wait cpu_hold=1 required 0 within 50 cycles");
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    // A byte offered while idle must be dropped, not buffered into the next header.
    bus.rx_data  = 8'hFF;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (bus.upg_done !== 1'b1) begin errors++; $display("FAIL reset_upg_done got %b exp 1", bus.upg_done); end
    checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_cpu_hold got %b exp 0", bus.cpu_hold); end
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b exp 0", bus.rx_ready); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
    checks++; if (bus.words_loaded !== '0) begin errors++; $display("FAIL reset_words got %0d exp 0", bus.words_loaded); end
    checks++; if (bus.upg_adr !== '0 || bus.upg_dat !== '0) begin errors++; $display("FAIL reset_adr_dat got %h/%h exp 0/0", bus.upg_adr, bus.upg_dat); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL reset_no_wen got %0d writes exp 0", got_q.size()); end
  endtask

  task automatic test_two_words(input int gap_max, input int mid_start, input string tag);
    bq_t s;
    s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model(s);
    run_upload(s, gap_max, mid_start);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL %s_count got %0d exp 2", tag, got_q.size()); end
    checks++; if (got_q.size() < 1 || got_q[0] !== {ADDR_W'(0), 32'h12345678}) begin
      errors++; $display("FAIL %s_word0 got %h exp %h", tag, (got_q.size() > 0) ? got_q[0] : 'x, {ADDR_W'(0), 32'h12345678}); end
    checks++; if (got_q.size() < 2 || got_q[1] !== {ADDR_W'(1), 32'hDEADBEEF}) begin
      errors++; $display("FAIL %s_word1 got %h exp %h", tag, (got_q.size() > 1) ? got_q[1] : 'x, {ADDR_W'(1), 32'hDEADBEEF}); end
    checks++; if (bus.words_loaded !== LEN_W'(exp_words)) begin errors++; $display("FAIL %s_words got %0d exp %0d", tag, bus.words_loaded, exp_words); end
    checks++; if (bus.err !== exp_err) begin errors++; $display("FAIL %s_err got %b exp %b", tag, bus.err, exp_err); end
    checks++; if (done_rise < 0 || hold_fall - done_rise != 1) begin
      errors++; $display("FAIL %s_release_order done_rise %0d hold_fall %0d exp gap 1", tag, done_rise, hold_fall); end
    checks++; if (bus.upg_done !== 1'b1) begin errors++; $display("FAIL %s_upg_done got %b exp 1", tag, bus.upg_done); end
  endtask

  task automatic test_zero_len;
    bq_t s;
    s = '{8'h00, 8'h00};
    model(s);
    run_upload(s, 0, -1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL zero_len_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    checks++; if (bus.err !== exp_err) begin errors++; $display("FAIL zero_len_err got %b exp %b", bus.err, exp_err); end
    checks++; if (done_rise < 0 || hold_fall - done_rise != 1) begin
      errors++; $display("FAIL zero_len_release done_rise %0d hold_fall %0d exp gap 1", done_rise, hold_fall); end
  endtask

  task automatic test_oversize;
    bq_t s;
    bq_t ok;
    s = '{8'h01, 8'h40};
    model(s);
    run_upload(s, 1, -1);
    checks++; if (bus.err !== exp_err) begin errors++; $display("FAIL oversize_err got %b exp %b", bus.err, exp_err); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL oversize_no_wen got %0d writes exp 0", got_q.size()); end
    checks++; if (bus.cpu_hold !== 1'b0 || bus.upg_done !== 1'b1) begin
      errors++; $display("FAIL oversize_release hold %b done %b exp 0/1", bus.cpu_hold, bus.upg_done); end
    ok = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    model(ok);
    run_upload(ok, 0, -1);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL oversize_err_clear got %b exp 0", bus.err); end
    checks++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL oversize_next_load got %0d writes first %h exp %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 'x, exp_q[0]); end
  endtask

  task automatic test_random_loads;
    for (int it = 0; it < 5; it++) begin
      bq_t s;
      int  nw;
      nw = int'($urandom_range(4, 1));
      s.push_back(8'(nw));
      s.push_back(8'h00);
      for (int k = 0; k < 4 * nw; k++) s.push_back(8'($urandom));
      model(s);
      run_upload(s, int'($urandom_range(3, 0)), -1);
      checks++; if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count got %0d exp %0d", it, got_q.size(), exp_q.size()); end
      for (int w = 0; w < exp_q.size(); w++) begin
        checks++; if (w >= got_q.size() || got_q[w] !== exp_q[w]) begin
          errors++; $display("FAIL rand%0d_word%0d got %h exp %h", it, w, (w < got_q.size()) ? got_q[w] : 'x, exp_q[w]); end
      end
      checks++; if (bus.words_loaded !== LEN_W'(exp_words)) begin
        errors++; $display("FAIL rand%0d_words got %0d exp %0d", it, bus.words_loaded, exp_words); end
    end
  endtask

  task automatic test_reset_mid_load;
    bq_t s;
    s = '{8'h02, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1};
    got_q.delete();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int i = 0; i < s.size(); i++) send_byte(s[i], 0);
    checks++; if (got_q.size() != 1 || got_q[0] !== {ADDR_W'(0), 32'hA4A3A2A1}) begin
      errors++; $display("FAIL midrst_first_word got %0d writes first %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 'x); end
    checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL midrst_hold_before got %b exp 1", bus.cpu_hold); end
    rst = 1'b0;
    #1;
    checks++; if (bus.upg_done !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.rx_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_async done %b hold %b ready %b exp 1/0/0", bus.upg_done, bus.cpu_hold, bus.rx_ready); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall;
    bq_t rest;
    got_q.delete();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    send_byte(8'h01, 0);
`ifdef UPLOAD_TIMEOUT_EN
    repeat (105) @(negedge clk);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b exp 1", bus.err); end
    checks++; if (bus.cpu_hold !== 1'b0 || bus.upg_done !== 1'b1) begin
      errors++; $display("FAIL timeout_release hold %b done %b exp 0/1", bus.cpu_hold, bus.upg_done); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL timeout_no_wen got %0d exp 0", got_q.size()); end
`else
    repeat (120) @(negedge clk);
    checks++; if (bus.cpu_hold !== 1'b1 || bus.err !== 1'b0) begin
      errors++; $display("FAIL stall_wait hold %b err %b exp 1/0", bus.cpu_hold, bus.err); end
    rest = '{8'h00, 8'hC0, 8'hDE, 8'hFA, 8'hCE};
    for (int i = 0; i < rest.size(); i++) send_byte(rest[i], 0);
    repeat (4) @(negedge clk);
    checks++; if (got_q.size() != 1 || got_q[0] !== {ADDR_W'(0), 32'hCEFADEC0}) begin
      errors++; $display("FAIL stall_resume got %0d writes first %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 'x); end
    checks++; if (bus.cpu_hold !== 1'b0) begin errors++; $display("FAIL stall_release got %b exp 0", bus.cpu_hold); end
`endif
  endtask

  initial begin
    test_reset();
    test_two_words(0, -1, "two_words");
    test_zero_len();
    test_oversize();
    test_two_words(3, 5, "gaps_start");
    test_random_loads();
    test_reset_mid_load();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/rom_upload_ctrl.md
Name: rom_upload_ctrl

Overview:
Sequencer that owns the program ROM's upload port. It takes a byte stream from the UART receiver, assembles little-endian 32-bit words and writes them into the ROM through the upg_* interface while holding the CPU in reset. When the load finishes it returns ROM ownership to instruction fetch. It sits between the UART RX, the program ROM's upg_* inputs and the CPU core reset.

Parameters:
ADDR_W, 14, ROM word-address width; DEPTH = 2**ADDR_W words
LEN_W, 16, width of the word-count header field
TIMEOUT_CYCLES, 1000000, maximum allowed idle gap between accepted bytes (optional feature only)

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse (debounced button) requesting an upload
rx_data  input  8  byte from UART RX
rx_valid  input  1  rx_data is valid this cycle
rx_ready  output  1  controller accepts a byte this cycle
upg_wen  output  1  ROM write enable, one-cycle pulse per word
upg_adr  output  ADDR_W  ROM word address
upg_dat  output  32  ROM write data
upg_done  output  1  1 = ROM owned by fetch, CPU may run
cpu_hold  output  1  1 = hold CPU core in reset
err  output  1  sticky: last upload aborted; cleared on next start
words_loaded  output  LEN_W  words written in the current or last upload

Behaviour:
- Reset (rst=0, async): state IDLE; upg_done=1; cpu_hold=0; rx_ready=0; upg_wen=0; upg_adr=0; upg_dat=0; err=0; words_loaded=0.
- Byte handshake: a byte is consumed only in a cycle where rx_valid and rx_ready are both 1. rx_ready=1 only in LEN_LO, LEN_HI and DATA. rx_ready is a registered/state decode and never depends combinationally on rx_valid.
- States and transitions:
  - IDLE:
    - start=1 moves to LEN_LO.
    - Same edge: upg_done->0, cpu_hold->1, err->0, words_loaded->0, byte index->0, upg_adr->0.
  - LEN_LO: accepted byte gives len[7:0]; go to LEN_HI.
  - LEN_HI: accepted byte gives len[15:8].
    - len==0: go to DONE.
    - len>DEPTH: err->1, go to DONE.
    - Otherwise go to DATA.
  - DATA:
    - Accepted byte is shifted into word bits [8*idx+7:8*idx]; idx is a 2-bit counter.
    - On the 4th byte (idx==3) go to WRITE.
  - WRITE: exactly one cycle.
    - upg_wen=1, upg_dat=assembled word, upg_adr=current word index.
    - Next cycle: upg_adr increments and words_loaded increments.
    - If words_loaded+1==len go to DONE, else return to DATA.
  - DONE: exactly one cycle; upg_done->1. The next cycle cpu_hold->0 and state->IDLE, so the CPU leaves reset one cycle after ROM ownership returns.
- start is ignored outside IDLE.
- Latency: 4 accepted bytes to upg_wen pulse is 1 cycle (WRITE directly follows the 4th accepted byte). Minimum cost is 5 cycles per word.
- upg_adr wraps modulo DEPTH but cannot reach wrap, because len>DEPTH is rejected. len==DEPTH is legal and writes addresses 0..DEPTH-1.
- rx_valid pulses while rx_ready=0 are dropped; they are not buffered.
- Reset mid-upload returns to IDLE with upg_done=1. ROM contents are partially written and no recovery is attempted.

Optional Feature:
- Macro: UPLOAD_TIMEOUT_EN.
- Defined:
  - A counter clears on every accepted byte and on entry to LEN_LO, and counts while in LEN_LO/LEN_HI/DATA.
  - Reaching TIMEOUT_CYCLES-1 sets err=1 and goes to DONE, which releases the CPU.
- Not defined: no counter; the controller waits indefinitely for bytes. err is set only by len>DEPTH.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE)
  - ADDR_W/LEN_W defaults
  - the word-assembly byte-order constant (little-endian)
- One natural sub-module, upload_word_assembler: 2-bit index plus 32-bit shift register, with inputs byte/accept/clear and outputs word/word_full. Everything else stays in the top FSM.

Test Plan:
1. Reset then idle: rst low→high, no start -> upg_done=1, cpu_hold=0, rx_ready=0, upg_wen never pulses.
2. Load 2 words:
   - Stimulus: start, then bytes 02 00 | 78 56 34 12 | EF BE AD DE.
   - Required: upg_wen pulses twice, at (adr 0, dat 0x12345678) then (adr 1, dat 0xDEADBEEF).
   - Then upg_done=1, then cpu_hold=0 one cycle later; words_loaded=2, err=0.
3. Zero length: start, bytes 00 00 -> no upg_wen; DONE; upg_done=1; err=0.
4. Oversize: ADDR_W=14, header 01 40 (len=16385) -> err=1, no upg_wen, CPU released; next start clears err.
5. Gaps and ignored start: bytes spaced with random rx_valid gaps and a start pulse mid-DATA -> identical writes to test 2, and the mid-DATA start has no effect.
6. Reset mid-load: rst asserted after the 5th data byte -> immediate upg_done=1, cpu_hold=0, state IDLE. With UPLOAD_TIMEOUT_EN and TIMEOUT_CYCLES=100, stalling 100 cycles after the first header byte -> err=1 and the CPU is released.
